pow_seq_eval: RTL and testbench



---
 rtl/pow_seq_pkg.sv | 11 +
 rtl/pow_seq_mul.sv | 10 +
 rtl/pow_seq_eval.sv | 71 +++++++
 tb/tb_pow_seq_eval.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pow_seq_pkg.sv
// pow_seq_pkg: shared state and operand-classification encodings for pow_seq_eval
package pow_seq_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [2:0] CL_ONE   = 3'd0;
  localparam logic [2:0] CL_UNDEF = 3'd1;
  localparam logic [2:0] CL_ZERO  = 3'd2;
  localparam logic [2:0] CL_NEG1  = 3'd3;
  localparam logic [2:0] CL_ITER  = 3'd4;
endpackage

// File: rtl/pow_seq_mul.sv
// pow_seq_mul: combinational truncating multiplier, low W bits of x*y
module pow_seq_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] p
);
  assign p = x * y;
endmodule

// File: rtl/pow_seq_eval.sv
// pow_seq_eval: sequential square-and-multiply evaluator of a ** b with language-exact signedness rules
module pow_seq_eval
  import pow_seq_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic               a_signed,
  input  logic [B_WIDTH-1:0] b,
  input  logic               b_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH-1:0] y,
  output logic               y_undef
);
  logic [1:0]         state;
  logic [A_WIDTH-1:0] acc, base, m_acc, m_base, acc_nx;
  logic [B_WIDTH-1:0] exp;
  logic [2:0]         cls;
  logic               b_neg;
  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  pow_seq_mul #(.W(A_WIDTH)) u_mul_acc (.x(acc), .y(base), .p(m_acc));
  pow_seq_mul #(.W(A_WIDTH)) u_mul_sq (.x(base), .y(base), .p(m_base));
  // classify operands for the accept cycle and select the next accumulator
  always_comb begin
    b_neg  = b_signed & b[B_WIDTH-1];
    cls    = b == '0 ? CL_ONE :
             !b_neg ? CL_ITER :
             a == '0 ? CL_UNDEF :
             a == A_WIDTH'(1) ? CL_ONE :
             (a_signed && &a) ? (b[0] ? CL_NEG1 : CL_ONE) : CL_ZERO;
    acc_nx = exp[0] ? m_acc : acc;
  end
  // handshake FSM; RUN consumes one exponent bit per clock with no early exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      base    <= '0;
      exp     <= '0;
      y       <= '0;
      y_undef <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (in_valid) begin
        state   <= cls == CL_ITER ? ST_RUN : ST_DONE;
        acc     <= A_WIDTH'(1);
        base    <= a;
        exp     <= b;
        y       <= cls == CL_NEG1 ? '1 : cls == CL_ONE ? A_WIDTH'(1) : '0;
        y_undef <= cls == CL_UNDEF;
      end
    end else if (state == ST_RUN) begin
      acc   <= acc_nx;
      base  <= m_base;
      exp   <= exp >> 1;
      if ((exp >> 1) == '0) begin
        state   <= ST_DONE;
        y       <= acc_nx;
        y_undef <= 1'b0;
      end
    end else begin
      if (out_ready) state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_pow_seq_eval.sv
// tb_pow_seq_eval: directed vectors with a result scoreboard for pow_seq_eval
module tb_pow_seq_eval;
  logic       clk = 0, rst_n = 0;
  logic       in_valid = 0, in_ready, a_signed = 0, b_signed = 0;
  logic [7:0] a = 0, b = 0, y;
  logic       out_valid, out_ready = 1, y_undef;
  int         vectors = 0, errs = 0;
  logic [8:0] exp_q[$];

  pow_seq_eval #(.A_WIDTH(8), .B_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .a_signed(a_signed), .b(b), .b_signed(b_signed),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_undef(y_undef)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
    end
  endtask

  // scoreboard monitor: compares each result at the moment it is handed off
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("y", int'(y), int'(e[7:0]));
        check("y_undef", int'(y_undef), int'(e[8]));
      end
    end
  end

  task automatic issue(input string nm, input logic [7:0] ta, input logic tas,
                       input logic [7:0] tb_, input logic tbs,
                       input logic [7:0] ey, input logic eu, input int lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    check({nm, "_in_ready"}, int'(in_ready), 1);
    a = ta; a_signed = tas; b = tb_; b_signed = tbs; in_valid = 1;
    exp_q.push_back({eu, ey});
    @(posedge clk); #1;
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check({nm, "_latency"}, n, lat);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_y", int'(y), 0);
    check("rst_y_undef", int'(y_undef), 0);
    rst_n = 1;
    @(posedge clk); #1;
    issue("m2_pow_m2", 8'hFE, 1, 8'hFE, 1, 8'h00, 0, 1);
    issue("m1_pow_m3", 8'hFF, 1, 8'hFD, 1, 8'hFF, 0, 1);
    issue("m1_pow_m2", 8'hFF, 1, 8'hFE, 1, 8'h01, 0, 1);
    issue("zero_neg", 8'h00, 0, 8'hFF, 1, 8'h00, 1, 1);
    issue("ff_uns_neg", 8'hFF, 0, 8'hFF, 1, 8'h00, 0, 1);
    issue("one_neg", 8'h01, 0, 8'h80, 1, 8'h01, 0, 1);
    issue("zero_zero", 8'h00, 0, 8'h00, 0, 8'h01, 0, 1);
    issue("3_pow_2", 8'h03, 0, 8'h02, 0, 8'h09, 0, 3);
    issue("m3_pow_3", 8'hFD, 1, 8'h03, 0, 8'hE5, 0, 3);
    issue("3_pow_5", 8'h03, 0, 8'h05, 0, 8'hF3, 0, 4);
    issue("ff_uns_sq", 8'hFF, 0, 8'h02, 0, 8'h01, 0, 3);
    issue("m2_pow_254", 8'hFE, 1, 8'hFE, 0, 8'h00, 0, 9);
    issue("2_pow_255", 8'h02, 0, 8'hFF, 0, 8'h00, 0, 9);
    // backpressure: result held while a competing request waits
    out_ready = 0;
    issue("bp_3_pow_2", 8'h03, 0, 8'h02, 0, 8'h09, 0, 3);
    a = 8'h05; a_signed = 0; b = 8'h01; b_signed = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_y", int'(y), 9);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_no_same_cycle_accept", int'(in_ready), 1);
    check("bp_handoff_out_valid", int'(out_valid), 0);
    exp_q.push_back({1'b0, 8'h05});
    @(posedge clk); #1;
    in_valid = 0;
    check("bp_second_accepted", int'(in_ready), 0);
    @(posedge clk); #1;
    check("bp_second_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    // asynchronous reset in the third RUN clock of the 254 case
    a = 8'hFE; a_signed = 1; b = 8'hFE; b_signed = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("run_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_y", int'(y), 0);
    check("arst_y_undef", int'(y_undef), 0);
    @(posedge clk); #1;
    rst_n = 1;
    issue("post_rst_2_pow_3", 8'h02, 0, 8'h03, 0, 8'h08, 0, 3);
    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
